ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage between the ID/EX pipeline register and the EX/MEM register.
- Consumes the decoded operands and control flags, and computes single-cycle ALU results.
- Runs an iterative 32-cycle unsigned multiply/divide unit that writes HI/LO.
- Registers the result plus the memory and writeback flags for the MEM stage, and raises stall upstream while the multiply/divide unit is busy.

Parameters:
- MD_CYCLES, 32, number of iterations for MULTU/DIVU; one iteration per cycle.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  instruction present from ID/EX.
- flush  in  1  kill the instruction in EX; the next registered output is a bubble.
- alu_function  in  4  operation code (encoding below).
- dato_A  in  32  rs operand.
- dato_B  in  32  rt operand; also the store data.
- SignExtImm  in  32  sign-extended immediate.
- shampt  in  5  shift amount.
- rd  in  5  R-type destination.
- rt  in  5  I-type destination.
- Mux_2_flag  in  1  ALU B source: 1 = SignExtImm, 0 = dato_B.
- Mux_3_flag  in  1  destination select: 1 = rd, 0 = rt.
- flag_mem_rd  in  1  load.
- flag_mem_wr  in  1  store.
- flag_banco_wr  in  1  register-file write.
- stall  out  1  upstream must hold its instruction; combinational.
- valid_out  out  1  registered; instruction valid into MEM.
- alu_result  out  32  registered result.
- store_data  out  32  registered copy of dato_B.
- dest_reg  out  5  registered destination.
- flag_mem_rd_out  out  1  registered.
- flag_mem_wr_out  out  1  registered.
- flag_banco_wr_out  out  1  registered.

Behaviour:
- alu_function encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU.
  - 8 SLL, 9 SRL, A SRA: shift dato_B by shampt.
  - B LUI: {B[15:0], 16'h0}.
  - C MULTU, D DIVU.
  - E MFHI, F MFLO.
- Arithmetic rules: ADD/SUB wrap modulo 2^32 with no overflow trap. Operand B is muxed by Mux_2_flag for ops 0-7 and B.
- Reset: clears all of the following on the same edge, regardless of state.
  - valid_out and all flag outputs = 0.
  - alu_result, store_data and dest_reg = 0.
  - HI = LO = 0.
  - FSM = IDLE, iteration count = 0, stall = 0.
- Single-cycle ops: 1-cycle latency; the result appears on outputs at the edge after acceptance.
- FSM states: IDLE, BUSY.
  - IDLE: valid_in & ~flush & op in {C,D} → BUSY.
    - Load count = MD_CYCLES and latch operands.
    - Output a bubble: valid_out=1, flag_banco_wr_out=0, mem flags=0, alu_result=0.
  - BUSY: stall=1. Each edge performs one shift-add (MULTU) or one restoring-division step (DIVU) and decrements count.
    - At the edge where count goes 1→0, write HI/LO and return to IDLE.
    - MULTU: {HI,LO} = A*B, 64-bit unsigned.
    - DIVU: LO = quotient, HI = remainder.
  - stall is high for exactly MD_CYCLES cycles after the accept edge. valid_out=0 on every edge while BUSY.
- Divide by zero: LO=32'hFFFFFFFF, HI=dividend; still takes MD_CYCLES cycles.
- MFHI/MFLO directly after MULTU/DIVU: held upstream by stall, then reads the new HI/LO.
- flush:
  - In IDLE: next outputs are all-zero with valid_out=0, and a C/D op is not started.
  - In BUSY: aborts the operation, HI/LO unchanged, FSM → IDLE on that edge, stall drops the following cycle.
- valid_in=0: bubble; all flag outputs = 0 and valid_out = 0.
- rst asserted while BUSY: abort, HI/LO = 0.

Decomposition:
- Shared package ex_pkg holds the alu_function code localparams (ALU_ADD..ALU_MFLO) and the FSM state encoding.
- One sub-module, muldiv_unit: contains the FSM, counter, HI/LO and the iterative datapath, with start/op/abort/busy ports.
- ALU and output registers stay in ex_stage.

Test Plan:
- ADD with dato_A=32'h7FFFFFFF, B=1, Mux_2_flag=0, Mux_3_flag=1, rd=5 → next edge alu_result=32'h80000000, dest_reg=5, valid_out=1.
- SRA with dato_B=32'h80000010, shampt=4 → alu_result=32'hF8000001; SLT with A=-1, B=1 → 1; SLTU with the same operands → 0.
- MULTU A=32'hFFFFFFFF, B=2, then MFHI held upstream → stall high for exactly 32 cycles, then MFHI result=1; MFLO result=32'hFFFFFFFE.
- DIVU A=100, B=7 → LO=14, HI=2; DIVU A=9, B=0 → LO=32'hFFFFFFFF, HI=9.
- flush asserted on cycle 10 of a DIVU → stall drops next cycle, HI/LO keep their prior values, valid_out=0.
- rst pulsed mid-MULTU, and a load with flag_mem_rd=1 accepted alongside flush → all outputs 0, stall=0; flush yields flag_mem_rd_out=0.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU operation codes and the
// multiply/divide sequencer state encoding.
package ex_pkg;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_AND   = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_XOR   = 4'h4;
  localparam logic [3:0] ALU_NOR   = 4'h5;
  localparam logic [3:0] ALU_SLT   = 4'h6;
  localparam logic [3:0] ALU_SLTU  = 4'h7;
  localparam logic [3:0] ALU_SLL   = 4'h8;
  localparam logic [3:0] ALU_SRL   = 4'h9;
  localparam logic [3:0] ALU_SRA   = 4'hA;
  localparam logic [3:0] ALU_LUI   = 4'hB;
  localparam logic [3:0] ALU_MULTU = 4'hC;
  localparam logic [3:0] ALU_DIVU  = 4'hD;
  localparam logic [3:0] ALU_MFHI  = 4'hE;
  localparam logic [3:0] ALU_MFLO  = 4'hF;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/ex_stage_muldiv_unit.sv
// Iterative unsigned multiply/divide with HI/LO. One shift-add or restoring
// step per cycle; HI/LO only update on the final iteration.
//   state   | meaning
//   MD_IDLE | waiting for start, HI/LO stable
//   MD_BUSY | iterating, count = steps remaining
module muldiv_unit
  import ex_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_op_div,
  input  logic        i_abort,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int CW = $clog2(MD_CYCLES + 1);

  md_state_t   r_state;
  md_state_t   w_state_nxt;
  logic [CW-1:0] r_count;
  logic        r_op_div;
  logic [31:0] r_opnd;
  logic [63:0] r_work;
  logic [63:0] w_work_nxt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [32:0] w_mul_sum;
  logic [32:0] w_rem_sh;
  logic [31:0] w_div_sub;
  logic        w_last;

  assign w_last = (r_count == CW'(1));
  assign o_busy = (r_state == MD_BUSY);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

  always_ff @(posedge clk) begin
    if (rst) r_state <= MD_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MD_IDLE: if (i_start) w_state_nxt = MD_BUSY;
      MD_BUSY: if (i_abort || w_last) w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  // r_work holds {partial product, multiplier} or {remainder, dividend/quotient};
  // both finish with HI in the upper half and LO in the lower half.
  always_comb begin
    w_mul_sum = {1'b0, r_work[63:32]} + (r_work[0] ? {1'b0, r_opnd} : 33'd0);
    w_rem_sh  = r_work[63:31];
    w_div_sub = w_rem_sh[31:0] - r_opnd;
    if (r_op_div) begin
      if (w_rem_sh >= {1'b0, r_opnd}) w_work_nxt = {w_div_sub, r_work[30:0], 1'b1};
      else                            w_work_nxt = {w_rem_sh[31:0], r_work[30:0], 1'b0};
    end else begin
      w_work_nxt = {w_mul_sum, r_work[31:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_op_div <= 1'b0;
      r_opnd   <= '0;
      r_work   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (r_state == MD_IDLE) begin
      if (i_start) begin
        r_count  <= CW'(MD_CYCLES);
        r_op_div <= i_op_div;
        r_opnd   <= i_op_div ? i_b : i_a;
        r_work   <= {32'd0, (i_op_div ? i_a : i_b)};
      end
    end else if (i_abort) begin
      r_count <= '0;
    end else begin
      r_work  <= w_work_nxt;
      r_count <= r_count - CW'(1);
      if (w_last) begin
        r_hi <= w_work_nxt[63:32];
        r_lo <= w_work_nxt[31:0];
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, iterative MULTU/DIVU via muldiv_unit,
// and the EX/MEM output register.
module ex_stage
  import ex_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        flush,
  input  logic [3:0]  alu_function,
  input  logic [31:0] dato_A,
  input  logic [31:0] dato_B,
  input  logic [31:0] SignExtImm,
  input  logic [4:0]  shampt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rt,
  input  logic        Mux_2_flag,
  input  logic        Mux_3_flag,
  input  logic        flag_mem_rd,
  input  logic        flag_mem_wr,
  input  logic        flag_banco_wr,
  output logic        stall,
  output logic        valid_out,
  output logic [31:0] alu_result,
  output logic [31:0] store_data,
  output logic [4:0]  dest_reg,
  output logic        flag_mem_rd_out,
  output logic        flag_mem_wr_out,
  output logic        flag_banco_wr_out
);

  logic        w_md_busy;
  logic [31:0] w_hi;
  logic [31:0] w_lo;
  logic        w_is_md;
  logic        w_accept;
  logic [31:0] w_op_b;
  logic [31:0] w_alu;

  assign w_is_md  = (alu_function == ALU_MULTU) || (alu_function == ALU_DIVU);
  assign w_accept = valid_in && !flush && !w_md_busy;
  assign w_op_b   = Mux_2_flag ? SignExtImm : dato_B;
  assign stall    = w_md_busy;

  muldiv_unit #(.MD_CYCLES(MD_CYCLES)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept && w_is_md),
    .i_op_div (alu_function == ALU_DIVU),
    .i_abort  (flush),
    .i_a      (dato_A),
    .i_b      (dato_B),
    .o_busy   (w_md_busy),
    .o_hi     (w_hi),
    .o_lo     (w_lo)
  );

  always_comb begin
    w_alu = '0;
    case (alu_function)
      ALU_ADD:  w_alu = dato_A + w_op_b;
      ALU_SUB:  w_alu = dato_A - w_op_b;
      ALU_AND:  w_alu = dato_A & w_op_b;
      ALU_OR:   w_alu = dato_A | w_op_b;
      ALU_XOR:  w_alu = dato_A ^ w_op_b;
      ALU_NOR:  w_alu = ~(dato_A | w_op_b);
      ALU_SLT:  w_alu = {31'd0, ($signed(dato_A) < $signed(w_op_b))};
      ALU_SLTU: w_alu = {31'd0, (dato_A < w_op_b)};
      ALU_SLL:  w_alu = dato_B << shampt;
      ALU_SRL:  w_alu = dato_B >> shampt;
      ALU_SRA:  w_alu = 32'($signed(dato_B) >>> shampt);
      ALU_LUI:  w_alu = {w_op_b[15:0], 16'h0000};
      ALU_MFHI: w_alu = w_hi;
      ALU_MFLO: w_alu = w_lo;
      default:  w_alu = '0;
    endcase
  end

  // A started MULTU/DIVU still leaves as a valid slot, but writes nothing.
  always_ff @(posedge clk) begin
    if (rst || !w_accept || w_is_md) begin
      valid_out         <= !rst && w_accept;
      alu_result        <= '0;
      store_data        <= '0;
      dest_reg          <= '0;
      flag_mem_rd_out   <= 1'b0;
      flag_mem_wr_out   <= 1'b0;
      flag_banco_wr_out <= 1'b0;
    end else begin
      valid_out         <= 1'b1;
      alu_result        <= w_alu;
      store_data        <= dato_B;
      dest_reg          <= Mux_3_flag ? rd : rt;
      flag_mem_rd_out   <= flag_mem_rd;
      flag_mem_wr_out   <= flag_mem_wr;
      flag_banco_wr_out <= flag_banco_wr;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected EX/MEM contents are queued when an
// instruction is driven and compared after the following rising edge.
module tb_ex_stage;
  import ex_pkg::*;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        flush;
  logic [3:0]  alu_function;
  logic [31:0] dato_A;
  logic [31:0] dato_B;
  logic [31:0] SignExtImm;
  logic [4:0]  shampt;
  logic [4:0]  rd;
  logic [4:0]  rt;
  logic        Mux_2_flag;
  logic        Mux_3_flag;
  logic        flag_mem_rd;
  logic        flag_mem_wr;
  logic        flag_banco_wr;
  logic        stall;
  logic        valid_out;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  dest_reg;
  logic        flag_mem_rd_out;
  logic        flag_mem_wr_out;
  logic        flag_banco_wr_out;

  ex_stage #(.MD_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush),
    .alu_function(alu_function), .dato_A(dato_A), .dato_B(dato_B),
    .SignExtImm(SignExtImm), .shampt(shampt), .rd(rd), .rt(rt),
    .Mux_2_flag(Mux_2_flag), .Mux_3_flag(Mux_3_flag),
    .flag_mem_rd(flag_mem_rd), .flag_mem_wr(flag_mem_wr), .flag_banco_wr(flag_banco_wr),
    .stall(stall), .valid_out(valid_out), .alu_result(alu_result),
    .store_data(store_data), .dest_reg(dest_reg),
    .flag_mem_rd_out(flag_mem_rd_out), .flag_mem_wr_out(flag_mem_wr_out),
    .flag_banco_wr_out(flag_banco_wr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] st;
    logic [4:0]  d;
    logic [3:0]  ctl;
  } exp_t;

  exp_t        sb[$];
  string       sb_tag[$];
  exp_t        e_mon;
  string       t_mon;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e_mon = sb.pop_front();
      t_mon = sb_tag.pop_front();
      check({t_mon, ".res"}, 64'(alu_result), 64'(e_mon.res));
      check({t_mon, ".store"}, 64'(store_data), 64'(e_mon.st));
      check({t_mon, ".dest"}, 64'(dest_reg), 64'(e_mon.d));
      check({t_mon, ".valid_flags"},
            64'({valid_out, flag_mem_rd_out, flag_mem_wr_out, flag_banco_wr_out}),
            64'(e_mon.ctl));
    end
  end

  task automatic expect_out(input string tag, input logic v, input logic [31:0] res,
                            input logic [31:0] st, input logic [4:0] d, input logic [2:0] fl);
    exp_t e;
    e.res = res; e.st = st; e.d = d; e.ctl = {v, fl};
    sb.push_back(e);
    sb_tag.push_back(tag);
  endtask

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, b, imm,
                                            input logic [4:0] sh, input logic m2);
    logic [31:0] bo;
    bo = m2 ? imm : b;
    case (op)
      4'h0: return a + bo;
      4'h1: return a - bo;
      4'h2: return a & bo;
      4'h3: return a | bo;
      4'h4: return a ^ bo;
      4'h5: return ~(a | bo);
      4'h6: return ($signed(a) < $signed(bo)) ? 32'd1 : 32'd0;
      4'h7: return (a < bo) ? 32'd1 : 32'd0;
      4'h8: return b << sh;
      4'h9: return b >> sh;
      4'hA: return 32'($signed(b) >>> sh);
      4'hB: return {bo[15:0], 16'h0};
      4'hE: return m_hi;
      4'hF: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic md_model(input logic div, input logic [31:0] a, b);
    logic [63:0] p;
    if (!div) begin
      p = 64'(a) * 64'(b);
      m_hi = p[63:32];
      m_lo = p[31:0];
    end else if (b == 0) begin
      m_hi = a;
      m_lo = 32'hFFFF_FFFF;
    end else begin
      m_hi = a % b;
      m_lo = a / b;
    end
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a, b, imm,
                       input logic [4:0] sh, rdv, rtv, input logic m2, m3, mrd, mwr, bwr,
                       input logic [31:0] exp_res);
    valid_in = 1'b1; flush = 1'b0; alu_function = op;
    dato_A = a; dato_B = b; SignExtImm = imm; shampt = sh; rd = rdv; rt = rtv;
    Mux_2_flag = m2; Mux_3_flag = m3;
    flag_mem_rd = mrd; flag_mem_wr = mwr; flag_banco_wr = bwr;
    if (op == ALU_MULTU || op == ALU_DIVU) expect_out(tag, 1'b1, '0, '0, '0, 3'b000);
    else expect_out(tag, 1'b1, exp_res, b, m3 ? rdv : rtv, {mrd, mwr, bwr});
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (stall && n < 100) begin
      expect_out(tag, 1'b0, '0, '0, '0, 3'b000);
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0]  op;
    logic [31:0] a, b, imm;
    logic [4:0]  sh;
    logic        m2, m3;
    logic [2:0]  fl;

    rst = 1'b1; valid_in = 1'b0; flush = 1'b0; alu_function = '0;
    dato_A = '0; dato_B = '0; SignExtImm = '0; shampt = '0; rd = '0; rt = '0;
    Mux_2_flag = 1'b0; Mux_3_flag = 1'b0;
    flag_mem_rd = 1'b0; flag_mem_wr = 1'b0; flag_banco_wr = 1'b0;

    @(negedge clk);
    expect_out("reset", 1'b0, '0, '0, '0, 3'b000);
    @(negedge clk);
    check("reset_stall", 64'(stall), 64'd0);
    rst = 1'b0;

    issue("mfhi_after_reset", ALU_MFHI, 0, 0, 0, 0, 5'd2, 5'd3, 0, 1, 0, 0, 1, 32'd0);
    issue("add_wrap", ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 0, 5'd5, 5'd9, 0, 1, 0, 0, 1, 32'h8000_0000);
    issue("sra", ALU_SRA, 32'd0, 32'h8000_0010, 32'd0, 5'd4, 5'd1, 5'd3, 0, 0, 0, 0, 1, 32'hF800_0001);
    issue("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 5'd4, 5'd6, 0, 1, 0, 0, 1, 32'd1);
    issue("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 5'd4, 5'd6, 0, 1, 0, 0, 1, 32'd0);
    issue("addi_neg", ALU_ADD, 32'd16, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 5'd1, 5'd8, 1, 0, 0, 0, 1, 32'd15);
    issue("lui", ALU_LUI, 32'd0, 32'd0, 32'h0000_1234, 0, 5'd1, 5'd10, 1, 0, 0, 0, 1, 32'h1234_0000);
    issue("store", ALU_ADD, 32'h100, 32'hCAFE_0001, 32'd8, 0, 5'd0, 5'd11, 1, 0, 0, 1, 0, 32'h108);
    issue("load", ALU_ADD, 32'h200, 32'd0, 32'd4, 0, 5'd0, 5'd12, 1, 0, 1, 0, 1, 32'h204);

    for (int i = 0; i < 16; i++) begin
      op  = 4'($urandom_range(0, 11));
      a   = $urandom; b = $urandom; imm = $urandom;
      sh  = 5'($urandom_range(0, 31));
      m2  = 1'($urandom_range(0, 1)); m3 = 1'($urandom_range(0, 1));
      fl  = 3'($urandom_range(0, 7));
      issue("rand_alu", op, a, b, imm, sh, 5'($urandom), 5'($urandom), m2, m3,
            fl[2], fl[1], fl[0], alu_model(op, a, b, imm, sh, m2));
    end

    issue("multu_start", ALU_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    valid_in = 1'b1; alu_function = ALU_MFHI; rd = 5'd7; Mux_3_flag = 1'b1; flag_banco_wr = 1'b1;
    wait_idle("multu_busy", n);
    check("multu_stall_len", 64'(n), 64'd32);
    md_model(1'b0, 32'hFFFF_FFFF, 32'd2);
    issue("mfhi_mul", ALU_MFHI, 0, 0, 0, 0, 5'd7, 5'd0, 0, 1, 0, 0, 1, 32'd1);
    issue("mflo_mul", ALU_MFLO, 0, 0, 0, 0, 5'd8, 5'd0, 0, 1, 0, 0, 1, 32'hFFFF_FFFE);

    issue("divu_start", ALU_DIVU, 32'd100, 32'd7, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    wait_idle("divu_busy", n);
    check("divu_stall_len", 64'(n), 64'd32);
    md_model(1'b1, 32'd100, 32'd7);
    issue("mflo_div", ALU_MFLO, 0, 0, 0, 0, 5'd9, 5'd0, 0, 1, 0, 0, 1, 32'd14);
    issue("mfhi_div", ALU_MFHI, 0, 0, 0, 0, 5'd9, 5'd0, 0, 1, 0, 0, 1, 32'd2);

    issue("div0_start", ALU_DIVU, 32'd9, 32'd0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    wait_idle("div0_busy", n);
    check("div0_stall_len", 64'(n), 64'd32);
    md_model(1'b1, 32'd9, 32'd0);
    issue("mflo_div0", ALU_MFLO, 0, 0, 0, 0, 5'd9, 5'd0, 0, 1, 0, 0, 1, 32'hFFFF_FFFF);
    issue("mfhi_div0", ALU_MFHI, 0, 0, 0, 0, 5'd9, 5'd0, 0, 1, 0, 0, 1, 32'd9);

    issue("divu_flushed", ALU_DIVU, 32'd100, 32'd7, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      expect_out("divu_pre_flush", 1'b0, '0, '0, '0, 3'b000);
      @(negedge clk);
    end
    check("divu_busy_before_flush", 64'(stall), 64'd1);
    flush = 1'b1;
    expect_out("flush_busy", 1'b0, '0, '0, '0, 3'b000);
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_stall_drop", 64'(stall), 64'd0);
    issue("mfhi_after_abort", ALU_MFHI, 0, 0, 0, 0, 5'd3, 5'd0, 0, 1, 0, 0, 1, m_hi);
    issue("mflo_after_abort", ALU_MFLO, 0, 0, 0, 0, 5'd3, 5'd0, 0, 1, 0, 0, 1, m_lo);
    check("abort_hi_kept", 64'(m_hi), 64'd9);

    valid_in = 1'b1; flush = 1'b1; alu_function = ALU_MULTU; dato_A = 32'd3; dato_B = 32'd3;
    expect_out("flush_idle_md", 1'b0, '0, '0, '0, 3'b000);
    @(negedge clk);
    check("flush_idle_no_start", 64'(stall), 64'd0);
    alu_function = ALU_ADD; Mux_2_flag = 1'b1; SignExtImm = 32'd4; flag_mem_rd = 1'b1; flag_banco_wr = 1'b1;
    expect_out("flush_load", 1'b0, '0, '0, '0, 3'b000);
    @(negedge clk);
    flush = 1'b0; valid_in = 1'b0; flag_mem_wr = 1'b1;
    expect_out("invalid_bubble", 1'b0, '0, '0, '0, 3'b000);
    @(negedge clk);

    issue("multu_reset", ALU_MULTU, 32'd3, 32'd5, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      expect_out("multu_pre_rst", 1'b0, '0, '0, '0, 3'b000);
      @(negedge clk);
    end
    rst = 1'b1; valid_in = 1'b1; alu_function = ALU_ADD; flag_mem_rd = 1'b1; flag_banco_wr = 1'b1;
    expect_out("rst_mid_multu", 1'b0, '0, '0, '0, 3'b000);
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0;
    check("rst_mid_multu_stall", 64'(stall), 64'd0);
    m_hi = '0; m_lo = '0;
    issue("mfhi_after_rst", ALU_MFHI, 0, 0, 0, 0, 5'd1, 5'd0, 0, 1, 0, 0, 1, 32'd0);
    issue("mflo_after_rst", ALU_MFLO, 0, 0, 0, 0, 5'd1, 5'd0, 0, 1, 0, 0, 1, 32'd0);
    issue("sub_after_rst", ALU_SUB, 32'd5, 32'd7, 0, 0, 5'd2, 5'd0, 0, 1, 0, 0, 1, 32'hFFFF_FFFE);
    check("stall_idle_end", 64'(stall), 64'd0);

    @(negedge clk);
    @(negedge clk);
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
